bcd_serial_adder: RTL and testbench

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

---
 rtl/bcd_serial_adder.sv | 168 ++++++++++++++++
 tb/tb_bcd_serial_adder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per cycle, LSD first, IDLE/ADD/DONE control.
// Optional invalid-digit detection is enabled by defining BCD_SERIAL_CHECK_EN.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [3:0]         a_dig;
    logic [3:0]         b_dig;
    logic [4:0]         dig_res;
    logic               last_dig;

    // Decimal digit add: returns {carry, digit}; the +6 wraps mod 16 even for non-BCD inputs.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                                 input logic [3:0] y,
                                                 input logic       c);
        logic [4:0] t;
        logic [3:0] adj;
        t   = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        adj = t[3:0] + 4'd6;
        if (t > 5'd9) begin
            return {1'b1, adj};
        end
        return {1'b0, t[3:0]};
    endfunction

    assign a_dig    = a_q[{idx_q, 2'b00} +: 4];
    assign b_dig    = b_q[{idx_q, 2'b00} +: 4];
    assign dig_res  = bcd_digit_add(a_dig, b_dig, carry_q);
    assign last_dig = (idx_q == IDX_W'(DIGITS - 1));

`ifdef BCD_SERIAL_CHECK_EN
    logic err_q, err_d;
    logic dig_bad;

    assign dig_bad = (a_dig > 4'd9) || (b_dig > 4'd9);
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef BCD_SERIAL_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ADD;
`ifdef BCD_SERIAL_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ADD: begin
                sum_d[{idx_q, 2'b00} +: 4] = dig_res[3:0];
                carry_d = dig_res[4];
`ifdef BCD_SERIAL_CHECK_EN
                if (dig_bad) begin
                    err_d = 1'b1;
                end
`endif
                if (last_dig) begin
                    cout_d  = dig_res[4];
                    idx_d   = '0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Control and result state; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BCD_SERIAL_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef BCD_SERIAL_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Operand copies are pure data and are only ever read after a fresh load.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef BCD_SERIAL_CHECK_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (DIGITS=4) with a result scoreboard.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;

`ifdef BCD_SERIAL_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int dec(input logic [15:0] x);
        int r;
        r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(x[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                chk("done_unexpected", done, 0);
            end else begin
                e = sb.pop_front();
                chk("sum", sum, e.sum);
                chk("cout", cout, e.cout);
                chk("err", err, e.err);
            end
        end
    end

    // mode 0: quiet inputs; 1: operands churn during ADD; 2: churn plus start re-asserted
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                          input logic exp_err, input int mode);
        exp_t e;
        int   s;
        int   k;
        int   done0;
        s      = dec(av) + dec(bv) + int'(cv);
        e.sum  = to_bcd(s % 10000);
        e.cout = (s >= 10000);
        e.err  = exp_err;
        sb.push_back(e);
        done0 = done_cnt;
        a = av; b = bv; cin = cv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("busy_op", busy, 1);
            if (k == 1) begin
                chk("sum_add_c1", sum, 0);
                chk("err_cleared", err, 0);
            end
            if (k == 2) chk("sum_add_c2", sum, {12'h000, e.sum[3:0]});
            if (done === 1'b1) break;
            @(posedge clk); #1;
            if (mode >= 1) begin
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            end
            if (mode == 2) start = 1'b1;
        end
        start = 1'b0;
        chk("latency", k, DIGITS + 1);
        @(posedge clk); #1;
        chk("one_done", done_cnt - done0, 1);
    endtask

    task automatic hold_chk(input logic [15:0] es, input logic ec, input logic ee);
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("hold_sum", sum, es);
        chk("hold_cout", cout, ec);
        chk("hold_err", err, ee);
        chk("hold_busy", busy, 0);
        chk("hold_done", done, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int done0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        hold_chk(16'h5555, 1'b0, 1'b0);

        // back-to-back issue in the first IDLE cycle after DONE
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h0999, 16'h0001, 1'b1, 1'b0, 0);
        run_op(16'h9999, 16'h9999, 1'b1, 1'b0, 0);

        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 2);

        // reset during ADD
        done0 = done_cnt;
        a = 16'h8888; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        chk("abort_done", done, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - done0, 0);

        run_op(16'h2468, 16'h1357, 1'b1, 1'b0, 0);
        run_op(16'h5678, 16'h4321, 1'b0, 1'b0, 1);

        run_op(16'h00A0, 16'h0000, 1'b0, ERR_EXP, 0);
        hold_chk(16'h0100, 1'b0, ERR_EXP);
        run_op(16'h0005, 16'h0004, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
